bcd_time_entry: RTL and testbench

Keypad-side digit assembler that turns a serial stream of BCD digits into the 7-bit binary phase durations Ta, Tpv and Tsv consumed by the timing controller and the display split logic. It accepts up to two decimal digits calculator-style, recombines them as tens*10+unit, range-checks the result, and commits it to the selected duration register on an enter strobe. The block holds the live duration registers, which the rest of the design reads continuously.

---
 rtl/bcd_time_entry.sv | 115 +++++++++++
 tb/tb_bcd_time_entry.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_entry.sv
// rtl/bcd_time_entry.sv - keypad BCD digit assembler committing Ta/Tpv/Tsv durations
// Two-digit calculator-style entry, range check on enter, idle timeout discards partial entries.
module bcd_time_entry #(
  parameter int TA_DEFAULT     = 3,
  parameter int TPV_DEFAULT    = 20,
  parameter int TSV_DEFAULT    = 10,
  parameter int T_MIN          = 1,
  parameter int T_MAX          = 99,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic [1:0] sel,
  input  logic       enter,
  input  logic       cancel,
  output logic [6:0] Ta,
  output logic [6:0] Tpv,
  output logic [6:0] Tsv,
  output logic [3:0] entryTens,
  output logic [3:0] entryUnit,
  output logic       busy,
  output logic       commit,
  output logic       error
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] MIN_V = 7'(T_MIN);
  localparam logic [6:0] MAX_V = 7'(T_MAX);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    value;
  logic          digit_ok;
  logic          value_ok;

  // tens*10 as shift-and-add; largest result is 99 so 7 bits never overflow
  always_comb begin
    value    = ({3'b000, entryTens} << 3) + ({3'b000, entryTens} << 1) + {3'b000, entryUnit};
    digit_ok = (digit <= 4'd9);
    value_ok = (value >= MIN_V) && (value <= MAX_V) && (sel != 2'b11);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      Ta        <= 7'(TA_DEFAULT);
      Tpv       <= 7'(TPV_DEFAULT);
      Tsv       <= 7'(TSV_DEFAULT);
      entryTens <= 4'd0;
      entryUnit <= 4'd0;
      busy      <= 1'b0;
      commit    <= 1'b0;
      error     <= 1'b0;
    end else begin
      commit <= 1'b0;
      error  <= 1'b0;
      if (cancel) begin
        state     <= EMPTY;
        cnt       <= '0;
        entryTens <= 4'd0;
        entryUnit <= 4'd0;
        busy      <= 1'b0;
      end else if (enter) begin
        if (state != EMPTY && value_ok) begin
          case (sel)
            2'b00:   Ta  <= value;
            2'b01:   Tpv <= value;
            2'b10:   Tsv <= value;
            default: ;
          endcase
          commit <= 1'b1;
        end else begin
          error <= 1'b1;
        end
        state     <= EMPTY;
        cnt       <= '0;
        entryTens <= 4'd0;
        entryUnit <= 4'd0;
        busy      <= 1'b0;
      end else if (digit_valid) begin
        if (!digit_ok) begin
          // a rejected digit is not activity; it still ages the entry but cannot itself expire it
          error <= 1'b1;
          if (state != EMPTY && cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          entryTens <= (state == EMPTY) ? 4'd0 : entryUnit;
          entryUnit <= digit;
          state     <= (state == EMPTY) ? ONE : TWO;
          cnt       <= '0;
          busy      <= 1'b1;
        end
      end else if (state != EMPTY) begin
        if (cnt == CNT_LAST) begin
          state     <= EMPTY;
          cnt       <= '0;
          entryTens <= 4'd0;
          entryUnit <= 4'd0;
          busy      <= 1'b0;
          error     <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_entry.sv
// tb/tb_bcd_time_entry.sv - scoreboard bench for bcd_time_entry
// Driver steps a digit-list reference model per cycle; monitor compares every registered output snapshot.
module tb_bcd_time_entry;

  localparam int T_OUT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [1:0] sel = 2'd0;
  logic       enter = 1'b0;
  logic       cancel = 1'b0;
  logic [6:0] Ta, Tpv, Tsv;
  logic [3:0] entryTens, entryUnit;
  logic       busy, commit, error;

  bcd_time_entry #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit), .sel(sel),
    .enter(enter), .cancel(cancel), .Ta(Ta), .Tpv(Tpv), .Tsv(Tsv),
    .entryTens(entryTens), .entryUnit(entryUnit), .busy(busy), .commit(commit), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ta, tpv, tsv;
    logic [3:0] tens, unit;
    logic       busy, commit, error;
  } snap_t;

  snap_t q[$];
  int    checks = 0;
  int    errors = 0;

  int m_digits[$];
  int m_ta, m_tpv, m_tsv, m_idle;

  function automatic void model_reset();
    m_digits.delete();
    m_ta = 3; m_tpv = 20; m_tsv = 10; m_idle = 0;
  endfunction

  function automatic snap_t model_step(input bit c, input bit e, input bit v, input int d, input int s);
    snap_t r;
    int    val;
    bit    cm = 0, er = 0;
    if (c) begin
      m_digits.delete(); m_idle = 0;
    end else if (e) begin
      if (m_digits.size() == 0) er = 1;
      else begin
        val = (m_digits.size() == 2) ? m_digits[0] * 10 + m_digits[1] : m_digits[0];
        if (val >= 1 && val <= 99 && s != 3) begin
          if (s == 0) m_ta = val; else if (s == 1) m_tpv = val; else m_tsv = val;
          cm = 1;
        end else er = 1;
      end
      m_digits.delete(); m_idle = 0;
    end else if (v) begin
      if (d > 9) begin
        er = 1;
        if (m_digits.size() != 0 && m_idle < T_OUT - 1) m_idle++;
      end else begin
        m_digits.push_back(d);
        if (m_digits.size() > 2) void'(m_digits.pop_front());
        m_idle = 0;
      end
    end else if (m_digits.size() != 0) begin
      m_idle++;
      if (m_idle >= T_OUT) begin
        m_digits.delete(); m_idle = 0; er = 1;
      end
    end
    r.ta = 7'(m_ta); r.tpv = 7'(m_tpv); r.tsv = 7'(m_tsv);
    r.tens = (m_digits.size() == 2) ? 4'(m_digits[0]) : 4'd0;
    r.unit = (m_digits.size() >= 1) ? 4'(m_digits[m_digits.size() - 1]) : 4'd0;
    r.busy = (m_digits.size() != 0);
    r.commit = cm; r.error = er;
    return r;
  endfunction

  function automatic snap_t dut_snap();
    snap_t a;
    a.ta = Ta; a.tpv = Tpv; a.tsv = Tsv; a.tens = entryTens; a.unit = entryUnit;
    a.busy = busy; a.commit = commit; a.error = error;
    return a;
  endfunction

  task automatic cyc(input bit c, input bit e, input bit v, input int d, input int s);
    @(negedge clk);
    cancel = c; enter = e; digit_valid = v; digit = 4'(d); sel = 2'(s);
    q.push_back(model_step(c, e, v, d, s));
  endtask

  task automatic dig(input int d);
    cyc(0, 0, 1, d, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset(input string name);
    snap_t a, e;
    e = '0; e.ta = 7'd3; e.tpv = 7'd20; e.tsv = 7'd10;
    a = dut_snap();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  always @(posedge clk) begin
    snap_t e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = dut_snap();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL snapshot t=%0t: got Ta=%0d Tpv=%0d Tsv=%0d echo=%0d/%0d busy=%b commit=%b error=%b required Ta=%0d Tpv=%0d Tsv=%0d echo=%0d/%0d busy=%b commit=%b error=%b",
                 $time, a.ta, a.tpv, a.tsv, a.tens, a.unit, a.busy, a.commit, a.error,
                 e.ta, e.tpv, e.tsv, e.tens, e.unit, e.busy, e.commit, e.error);
      end
    end
  end

  initial begin
    int r, wait_cnt;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    dig(2); dig(5); cyc(0, 1, 0, 0, 1); idle(2);
    dig(1); dig(2); dig(7); cyc(0, 1, 0, 0, 0); idle(1);
    dig(0); cyc(0, 1, 0, 0, 2); idle(1);
    cyc(0, 0, 1, 12, 0); idle(1);
    dig(5); cyc(0, 1, 0, 0, 3); idle(1);
    cyc(0, 1, 0, 0, 1); idle(1);
    dig(3); dig(3); cyc(1, 1, 0, 0, 0); idle(1);
    dig(4); cyc(0, 1, 1, 9, 0); idle(1);
    dig(9); dig(9); cyc(0, 1, 0, 0, 2); idle(1);
    dig(1); cyc(0, 1, 0, 0, 1); idle(1);
    dig(8); idle(17);
    dig(8); idle(14); dig(1); idle(17);
    dig(6); dig(6); dig(6); cyc(0, 0, 1, 15, 0); cyc(0, 1, 0, 0, 1);

    dig(7); idle(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_entry");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)      dig(int'($urandom_range(0, 9)));
      else if (r < 39) cyc(0, 0, 1, int'($urandom_range(10, 15)), 0);
      else if (r < 49) cyc(0, 1, 0, 0, int'($urandom_range(0, 3)));
      else if (r < 53) cyc(1, 0, 0, 0, 0);
      else if (r < 58) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1,
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      else if (r < 62) idle(int'($urandom_range(12, 20)));
      else             idle(1);
    end
    idle(2);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
